// File: rtl/cl_fifo_packer_pkg.sv
// Shared definitions for the FIFO packer and its matching unpacker.
package cl_fifo_packer_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;
   localparam int unsigned DEFAULT_RATIO  = 4;

   // Lane count must represent 0..ratio inclusive, so one more code than lanes.
   function automatic int unsigned lane_cnt_w(input int unsigned ratio);
      return $clog2(ratio + 1);
   endfunction

   typedef logic [DEFAULT_DATA_W*DEFAULT_RATIO-1:0] packed_word_t;

endpackage

// File: rtl/cl_fifo_packer.sv
// Packs RATIO narrow FWFT-FIFO elements into one wide word, with flush of partial words.
module cl_fifo_packer
   import cl_fifo_packer_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned RATIO  = DEFAULT_RATIO
) (
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic                            in_empty_i,
   output logic                            in_read_o,
   input  logic [DATA_W-1:0]               in_data_i,
   input  logic                            flush_i,
   input  logic                            out_full_i,
   output logic                            out_write_o,
   output logic [DATA_W*RATIO-1:0]         out_data_o,
   output logic [lane_cnt_w(RATIO)-1:0]    out_lanes_o
);

   localparam int unsigned CNT_W = lane_cnt_w(RATIO);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO);

   logic [RATIO-1:0][DATA_W-1:0] lanes_q, lanes_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         flush_pend_q, flush_pend_d;

   // A pending flush blocks new input so the flushed word cannot grow after the request.
   always_comb begin
      out_write_o = ((cnt_q == CNT_MAX) | (flush_pend_q & (cnt_q != '0))) & ~out_full_i;
      in_read_o   = ~in_empty_i & ~flush_pend_q & ((cnt_q < CNT_MAX) | out_write_o);
   end

   assign out_data_o  = lanes_q;
   assign out_lanes_o = cnt_q;

   always_comb begin
      lanes_d = lanes_q;
      cnt_d   = cnt_q;
      if (out_write_o) begin
         lanes_d = '0;
         cnt_d   = '0;
      end
      if (in_read_o) begin
         if (out_write_o) begin
            lanes_d[0] = in_data_i;
            cnt_d      = CNT_W'(1);
         end else begin
            for (int i = 0; i < RATIO; i++) begin
               if (cnt_q == CNT_W'(i)) lanes_d[i] = in_data_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // An empty-word flush retires itself at the next edge without writing.
      if (flush_pend_q) flush_pend_d = ~(out_write_o | (cnt_q == '0));
      else              flush_pend_d = flush_i;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         lanes_q      <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         lanes_q      <= lanes_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

endmodule

// File: tb/tb_cl_fifo_packer.sv
// Directed and random-stall bench for cl_fifo_packer with an output-word scoreboard.
module tb_cl_fifo_packer;

   localparam int DATA_W = 8;
   localparam int RATIO  = 4;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        in_empty_i;
   logic        in_read_o;
   logic [7:0]  in_data_i;
   logic        flush_i;
   logic        out_full_i;
   logic        out_write_o;
   logic [31:0] out_data_o;
   logic [2:0]  out_lanes_o;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  lanes;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] in_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int writes_seen = 0;
   int stall_cnt = 0;
   bit stall_in = 1'b0;
   bit stall_out = 1'b0;

   always #5 clock_i = ~clock_i;

   cl_fifo_packer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .in_empty_i (in_empty_i),
      .in_read_o  (in_read_o),
      .in_data_i  (in_data_i),
      .flush_i    (flush_i),
      .out_full_i (out_full_i),
      .out_write_o(out_write_o),
      .out_data_o (out_data_o),
      .out_lanes_o(out_lanes_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      in_empty_i = (in_q.size() == 0) || stall_in;
      in_data_i  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      out_full_i = stall_out;
   endtask

   // One clock: check at the falling edge, advance the upstream FIFO model after the rising edge.
   task automatic cycle();
      bit   acc;
      exp_t e;
      @(negedge clock_i);
      chk("read_while_empty", 64'(in_read_o & in_empty_i), 64'd0);
      chk("write_while_full", 64'(out_write_o & out_full_i), 64'd0);
      if (!in_empty_i && in_read_o !== 1'b1) stall_cnt++;
      if (out_write_o === 1'b1 && !reset_i) begin
         writes_seen++;
         chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data_o), 64'(e.data));
            chk("out_lanes", 64'(out_lanes_o), 64'(e.lanes));
         end
      end
      acc = (in_read_o === 1'b1) && !in_empty_i && !reset_i;
      @(posedge clock_i);
      #1;
      if (acc) void'(in_q.pop_front());
      drive_inputs();
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n = 0;
      while ((in_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
         cycle();
         n++;
      end
      chk("drain_done", 64'(in_q.size() + exp_q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int s0;
      int n;
      int lane;
      logic [31:0] word;
      logic [7:0]  v;

      reset_i = 1'b1;
      flush_i = 1'b0;
      drive_inputs();
      cycle();
      cycle();
      chk("rst_write", 64'(out_write_o), 64'd0);
      chk("rst_read", 64'(in_read_o), 64'd0);
      chk("rst_data", 64'(out_data_o), 64'd0);
      chk("rst_lanes", 64'(out_lanes_o), 64'd0);
      reset_i = 1'b0;
      cycle();
      chk("idle_write", 64'(out_write_o), 64'd0);
      chk("idle_lanes", 64'(out_lanes_o), 64'd0);

      // streaming, downstream never full
      s0 = stall_cnt;
      for (int i = 1; i <= 8; i++) in_q.push_back(8'(i));
      exp_q.push_back('{32'h04030201, 3'd4});
      exp_q.push_back('{32'h08070605, 3'd4});
      drive_inputs();
      run_until_idle(50);
      chk("stream_no_stall", 64'(stall_cnt - s0), 64'd0);
      cycle();
      chk("stream_cnt_after", 64'(out_lanes_o), 64'd0);

      // back-pressure on a full word
      stall_out = 1'b1;
      for (int i = 1; i <= 5; i++) in_q.push_back(8'(i));
      exp_q.push_back('{32'h04030201, 3'd4});
      exp_q.push_back('{32'h00000005, 3'd1});
      drive_inputs();
      repeat (4) cycle();
      for (int k = 0; k < 5; k++) begin
         chk("bp_write", 64'(out_write_o), 64'd0);
         chk("bp_read", 64'(in_read_o), 64'd0);
         chk("bp_data", 64'(out_data_o), 64'h04030201);
         chk("bp_lanes", 64'(out_lanes_o), 64'd4);
         cycle();
      end
      stall_out = 1'b0;
      drive_inputs();
      cycle();
      chk("bp_released_word", 64'(exp_q.size()), 64'd1);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      run_until_idle(10);
      cycle();

      // partial flush
      in_q.push_back(8'hAA);
      in_q.push_back(8'hBB);
      exp_q.push_back('{32'h0000BBAA, 3'd2});
      drive_inputs();
      cycle();
      cycle();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      w0 = writes_seen;
      cycle();
      chk("pf_one_write", 64'(writes_seen - w0), 64'd1);
      chk("pf_cnt_zero", 64'(out_lanes_o), 64'd0);
      chk("pf_data_zero", 64'(out_data_o), 64'd0);
      cycle();
      chk("pf_no_extra", 64'(writes_seen - w0), 64'd1);

      // empty flush
      w0 = writes_seen;
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      cycle();
      cycle();
      chk("ef_no_write", 64'(writes_seen - w0), 64'd0);

      // accept with flush, then a second flush while one is pending
      in_q.push_back(8'hDD);
      drive_inputs();
      cycle();
      in_q.push_back(8'hCC);
      drive_inputs();
      exp_q.push_back('{32'h0000CCDD, 3'd2});
      flush_i = 1'b1;
      cycle();
      w0 = writes_seen;
      cycle();
      flush_i = 1'b0;
      cycle();
      cycle();
      chk("awf_single_write", 64'(writes_seen - w0), 64'd1);
      chk("awf_exp_empty", 64'(exp_q.size()), 64'd0);

      // reset in the middle of a word
      in_q.push_back(8'hE1);
      in_q.push_back(8'hE2);
      in_q.push_back(8'hE3);
      drive_inputs();
      repeat (3) cycle();
      w0 = writes_seen;
      reset_i = 1'b1;
      cycle();
      reset_i = 1'b0;
      chk("mid_rst_lanes", 64'(out_lanes_o), 64'd0);
      chk("mid_rst_data", 64'(out_data_o), 64'd0);
      for (int i = 0; i < 4; i++) in_q.push_back(8'(8'h11 + i));
      exp_q.push_back('{32'h14131211, 3'd4});
      drive_inputs();
      run_until_idle(20);
      chk("mid_rst_writes", 64'(writes_seen - w0), 64'd1);

      // random-stall soak
      lane = 0;
      word = '0;
      for (int i = 0; i < 10000; i++) begin
         v = 8'($urandom);
         in_q.push_back(v);
         word[lane*8 +: 8] = v;
         lane++;
         if (lane == RATIO) begin
            exp_q.push_back('{word, 3'd4});
            word = '0;
            lane = 0;
         end
      end
      n = 0;
      while ((in_q.size() != 0 || exp_q.size() != 0) && n < 40000) begin
         stall_in  = ($urandom_range(0, 3) == 0);
         stall_out = ($urandom_range(0, 2) == 0);
         drive_inputs();
         cycle();
         n++;
      end
      stall_in  = 1'b0;
      stall_out = 1'b0;
      drive_inputs();
      chk("soak_drained", 64'(in_q.size() + exp_q.size()), 64'd0);
      cycle();
      chk("soak_cnt_after", 64'(out_lanes_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
